// File: rtl/instr_encoder_if.sv
// Handshake and field bundle between an instruction producer and instr_encoder.
// The master modport belongs to the producer and consumer side, and the slave modport belongs to the encoder.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            immediate_source;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [31:0]           immediate;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           instruction;
  logic                  imm_error;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [7:0]            error_count;

  modport master (
    output in_valid, immediate_source, opcode, rd, rs1, rs2, funct3, funct7,
           immediate, out_ready,
    input  in_ready, out_valid, instruction, imm_error, instr_addr, error_count
  );

  modport slave (
    input  in_valid, immediate_source, opcode, rd, rs1, rs2, funct3, funct7,
           immediate, out_ready,
    output in_ready, out_valid, instruction, imm_error, instr_addr, error_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words through a two-stage valid/ready pipeline.
// Defining INSTR_ENCODER_ERR_COUNT_EN compiles in the saturating error_count register.
module instr_encoder #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic           clk,
  input  logic           reset,
  instr_encoder_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                  s1_valid;
  logic [31:0]           s1_word;
  logic                  s1_err;
  logic                  out_valid_q;
  logic [31:0]           instr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  s1_load;
  logic                  s2_load;
  logic                  out_xfer;
  logic [31:0]           imm;
  logic [31:0]           pack_word;
  logic                  pack_err;

  assign imm          = bus.immediate;
  assign s2_load      = !out_valid_q | bus.out_ready;
  assign s1_load      = !s1_valid | s2_load;
  assign out_xfer     = out_valid_q & bus.out_ready;
  assign bus.in_ready = !reset & s1_load;

  assign bus.out_valid   = out_valid_q;
  assign bus.instruction = instr_q;
  assign bus.imm_error   = err_q;
  assign bus.instr_addr  = addr_q;

  // The range check is done on the raw bits. A field is representable when its sign bits agree.
  always_comb begin
    pack_word = NOP;
    pack_err  = 1'b0;
    case (bus.immediate_source)
      3'b000: begin
        pack_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        pack_err  = !((&imm[31:11]) | (~|imm[31:11]));
      end
      3'b001: begin
        pack_word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
        pack_err  = !((&imm[31:11]) | (~|imm[31:11]));
      end
      3'b010: begin
        pack_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1],
                     imm[11], bus.opcode};
        pack_err  = !((&imm[31:12]) | (~|imm[31:12])) | imm[0];
      end
      3'b011: begin
        pack_word = {imm[31:12], bus.rd, bus.opcode};
        pack_err  = |imm[11:0];
      end
      3'b100: begin
        pack_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
        pack_err  = !((&imm[31:20]) | (~|imm[31:20])) | imm[0];
      end
      3'b101: begin
        pack_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        pack_err  = 1'b0;
      end
      default: pack_err = 1'b1;
    endcase
    if (pack_err) pack_word = NOP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_word     <= '0;
      s1_err      <= 1'b0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      addr_q      <= BASE_ADDR;
    end else begin
      if (out_xfer) addr_q <= addr_q + 1'b1;
      if (s2_load) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          instr_q <= s1_word;
          err_q   <= s1_err;
        end
      end
      if (s1_load) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_word <= pack_word;
          s1_err  <= pack_err;
        end
      end
    end
  end

`ifdef INSTR_ENCODER_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (out_xfer & err_q & (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.error_count = err_cnt_q;
`else
  assign bus.error_count = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. A queue-based scoreboard is checked every cycle, and literal checks pin the scoreboard's expected values.
module tb_instr_encoder;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(2'd0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] w;
    logic        e;
    longint      acc;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  longint      cyc = 0;
  exp_t        q[$];
  logic [31:0] got_w[$];
  logic        got_e[$];
  int          got_a[$];
  int          m_addr = 0;
  int          m_ecnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word computed from the specification: a numeric range check plus mask-and-shift packing.
  function automatic logic [32:0] model_enc(int unsigned src, int unsigned op, int unsigned rd,
                                            int unsigned rs1, int unsigned rs2, int unsigned f3,
                                            int unsigned f7, logic [31:0] imm);
    longint      v = longint'($signed(imm));
    int unsigned u = imm;
    bit          ok;
    int unsigned w;
    ok = 1'b0;
    w  = 0;
    case (src)
      0: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      1: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((u & 31) << 7) | op;
      end
      2: begin
        ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
           | (f3 << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | op;
      end
      3: begin
        ok = (u % 4096) == 0;
        w  = (u & 32'hFFFFF000) | (rd << 7) | op;
      end
      4: begin
        ok = (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
           | (((u >> 12) & 255) << 12) | (rd << 7) | op;
      end
      5: begin
        ok = 1'b1;
        w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h13;
    return {~ok, w};
  endfunction

  function automatic int exp_ecnt(int m);
`ifdef INSTR_ENCODER_ERR_COUNT_EN
    return m;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers seen at a falling edge take effect at the next rising edge.
  always @(negedge clk) begin
    logic [32:0] r;
    exp_t        e;
    bit          exp_ov;
    if (reset) begin
      chk("in_ready_in_reset", bus.in_ready, 0);
      q.delete();
      m_addr = 0;
      m_ecnt = 0;
    end else begin
      exp_ov = 1'b0;
      if (q.size() > 0) exp_ov = (cyc >= q[0].acc + 2);
      chk("out_valid", bus.out_valid, exp_ov);
      chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
      chk("error_count", bus.error_count, exp_ecnt(m_ecnt));
      if (bus.out_valid && q.size() > 0) begin
        chk("instruction", bus.instruction, q[0].w);
        chk("imm_error", bus.imm_error, q[0].e);
        chk("instr_addr", bus.instr_addr, m_addr);
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        got_w.push_back(bus.instruction);
        got_e.push_back(bus.imm_error);
        got_a.push_back(int'(bus.instr_addr));
        e = q.pop_front();
        m_addr = (m_addr + 1) % (1 << AW);
        if (e.e && m_ecnt < 255) m_ecnt++;
      end
      if (bus.in_valid && bus.in_ready) begin
        r = model_enc(bus.immediate_source, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                      bus.funct3, bus.funct7, bus.immediate);
        e.w   = r[31:0];
        e.e   = r[32];
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(logic [2:0] src, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                      logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
    bus.immediate_source = src;
    bus.opcode           = op;
    bus.rd               = rd;
    bus.rs1              = rs1;
    bus.rs2              = rs2;
    bus.funct3           = f3;
    bus.funct7           = f7;
    bus.immediate        = imm;
    bus.in_valid         = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    total++;
    bad++;
    $display("FAIL send_timeout actual=no_accept required=accept at %0t", $time);
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
  endtask

  initial begin
    int n;
    int base;
    bit acc;
    reset                = 1'b1;
    bus.in_valid         = 1'b0;
    bus.out_ready        = 1'b0;
    bus.immediate_source = '0;
    bus.opcode           = '0;
    bus.rd               = '0;
    bus.rs1              = '0;
    bus.rs2              = '0;
    bus.funct3           = '0;
    bus.funct7           = '0;
    bus.immediate        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_instruction", bus.instruction, 0);
    chk("rst_imm_error", bus.imm_error, 0);
    chk("rst_instr_addr", bus.instr_addr, 0);
    chk("rst_error_count", bus.error_count, 0);
    reset = 1'b0;

    // Directed formats with out_ready held high.
    bus.out_ready = 1'b1;
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    send(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    send(3'b011, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send(3'b011, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    send(3'b101, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF);
    drain();
    chk("n_words", got_w.size(), 8);
    chk("w0_I", got_w[0], 32'h0050_0093);
    chk("w1_S", got_w[1], 32'h0020_A423);
    chk("w2_B", got_w[2], 32'hFE00_0EE3);
    chk("w3_B_bad", got_w[3], 32'h0000_0013);
    chk("e3_B_bad", got_e[3], 1);
    chk("w4_J", got_w[4], 32'h0010_00EF);
    chk("w5_U", got_w[5], 32'h1234_52B7);
    chk("w6_U_bad", got_w[6], 32'h0000_0013);
    chk("e6_U_bad", got_e[6], 1);
    chk("w7_R", got_w[7], 32'h0020_81B3);
    chk("e0", got_e[0], 0);
    chk("e1", got_e[1], 0);
    for (int i = 0; i < 5; i++) chk("addr_seq", got_a[i], i % 4);
    chk("ecnt_after_dir", bus.error_count, exp_ecnt(2));

    // Stall: in_valid held high with out_ready low for five cycles.
    bus.out_ready        = 1'b0;
    bus.immediate_source = 3'b000;
    bus.opcode           = 7'h13;
    bus.rd               = 5'd1;
    bus.rs1              = 5'd0;
    bus.funct3           = 3'd0;
    bus.immediate        = 32'd10;
    bus.in_valid         = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        n++;
        bus.immediate = 32'(10 + n);
      end
    end
    bus.in_valid = 1'b0;
    chk("stall_accepts", n, 2);
    chk("stall_in_ready", bus.in_ready, 0);
    base = got_w.size();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_throughput", got_w.size() - base, 2);
    chk("stall_w0", got_w[base], 32'h00A0_0093);
    chk("stall_w1", got_w[base+1], 32'h00B0_0093);
    drain();

    // Reset while a word is waiting at the output.
    bus.out_ready = 1'b0;
    send(3'b000, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    chk("pre_rst_addr", bus.instr_addr, 2);
    chk("pre_rst_ecnt", bus.error_count, exp_ecnt(2));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_addr", bus.instr_addr, 0);
    chk("post_rst_ecnt", bus.error_count, 0);

    // Saturation: 260 reserved-format bundles.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 260; i++)
      send(3'b110, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("sat_ecnt", bus.error_count, exp_ecnt(255));
    chk("sat_last_w", got_w[got_w.size()-1], 32'h0000_0013);
    chk("sat_last_e", got_e[got_e.size()-1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the immediate decode path: accepts decoded instruction fields (opcode, registers, functs, immediate type and a 32-bit immediate value in its sign-extended form) and packs them into a 32-bit RV32I instruction word. It checks that the immediate can be represented in the selected format and emits each word with a sequential instruction-memory word address. It sits in front of the instruction-memory write port and is used by program loaders and self-test sequencers.

## Interface
- ADDR_WIDTH, 8, width of instruction word address.
- BASE_ADDR, 0, `instr_addr` value after reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept the bundle this cycle.
- immediate_source  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R (no immediate), 110/111 reserved.
- opcode  in  7  instruction[6:0].
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3; funct7  in  7.
- immediate  in  32  immediate value in its sign-extended form.
- out_valid  out  1  packed word valid.
- out_ready  in  1  consumer accepts the word.
- instruction  out  32  packed word.
- imm_error  out  1  word was replaced by a NOP because of an error.
- instr_addr  out  ADDR_WIDTH  word address of the current output.
- error_count  out  8  saturating count of error words delivered.

## Operation
- Two-stage valid/ready pipeline:
  - S1 captures the field bundle and computes the range check.
  - S2 holds the packed word and the error flag.
- Transfers:
  - Input transfer when `in_valid & in_ready`.
  - Output transfer when `out_valid & out_ready`.
- Load conditions:
  - S2 loads when `!out_valid | out_ready`.
  - S1 loads when `!s1_valid | s2_load`.
  - `in_ready = !reset & (!s1_valid | s2_load)`, a combinational function of `out_ready`.
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; `immediate` is ignored.
- Range check (failure means error):
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - 110/111: always an error.
- On error: `instruction` = 0x00000013 (NOP) and `imm_error` = 1. Otherwise `imm_error` = 0.
- `instr_addr` increments by 1 on each output transfer and wraps modulo 2^ADDR_WIDTH.
- `error_count` increments on each output transfer with `imm_error`=1 and saturates at 255.

## Timing
- Reset values:
  - `out_valid` 0, `instruction` 0, `imm_error` 0.
  - `instr_addr` BASE_ADDR, `error_count` 0.
  - `in_ready` 0 while `reset` is high.
  - S1 is empty.
- Latency: a bundle accepted at edge k is presented with `out_valid`=1 after edge k+1 if S2 is free.
- Throughput: one word per cycle while `out_ready`=1.
- Stall: `instruction`, `imm_error` and `instr_addr` hold stable while `out_valid & !out_ready`. At most 2 bundles are buffered; after that `in_ready`=0.
- Simultaneous events: an input transfer and an output transfer in the same cycle with both stages full must succeed with no bubble and no loss.
- Reset mid-operation: both stages are discarded and the counters are cleared; `out_valid`=0 on the cycle after the reset edge.
- Words are delivered in acceptance order.

## Configuration
- INSTR_ENCODER_ERR_COUNT_EN
  - Defined: the `error_count` register and its saturating logic are compiled in as described.
  - Undefined: `error_count` is tied to 0 and the counter logic is removed.
  - Packing, `imm_error` and NOP substitution are identical in both builds.

## Test plan
- I-type bundle (opcode 0010011, rd=1, rs1=0, funct3=0, imm=5), then S-type bundle (opcode 0100011, funct3=010, rs1=1, rs2=2, imm=8), with `out_ready`=1 -> 0x00500093 at addr 0, then 0x0020A423 at addr 1, `imm_error`=0.
- B-type beq (opcode 1100011, rs1=rs2=0, imm=0xFFFFFFFC) -> 0xFE000EE3. Same bundle with imm=3 -> 0x00000013, `imm_error`=1, `error_count`=1.
- J-type (opcode 1101111, rd=1, imm=0x800) -> 0x001000EF. U-type (opcode 0110111, rd=5, imm=0x12345000) -> 0x123452B7. U-type with imm=0x12345001 -> NOP, `imm_error`=1.
- `in_valid` held high and `out_ready`=0 for 5 cycles -> exactly 2 bundles accepted, `in_ready`=0 afterwards, outputs stable. Then `out_ready`=1 -> all words delivered in order, no duplicates, 1 word per cycle.
- ADDR_WIDTH=2, 5 valid words -> `instr_addr` sequence 0,1,2,3,0. Assert `reset` while `out_valid`=1 -> `out_valid`=0, `instr_addr`=BASE_ADDR and `error_count`=0 on the next cycle.
- 260 erroneous words with the macro defined -> `error_count`=255. Same run with the macro undefined -> `error_count`=0 and `instruction`/`imm_error` unchanged.
